// File: rtl/data_checker_if.sv
// AXI-Stream beat interface between the pattern generator and the checker.
interface data_checker_if #(
  parameter int unsigned DW = 512
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/data_checker.sv
// Checks a 64-bit incrementing counter stream, gathers beat/packet/error
// statistics, captures the first failing beat and throttles TREADY.
module data_checker #(
  parameter int unsigned DW = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [3:0]          throttle,
  data_checker_if.slave       axis_in,
  output logic                running,
  output logic [31:0]         beat_count,
  output logic [31:0]         packet_count,
  output logic [15:0]         error_count,
  output logic                error_flag,
  output logic [3:0]          first_err_code,
  output logic [63:0]         first_err_expected,
  output logic [63:0]         first_err_actual
);

  localparam int unsigned KW      = DW / 8;
  localparam int unsigned CNT_W   = 64;
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        phase;
  logic [CNT_W-1:0]  expected;

  logic              accept;
  logic              data_err;
  logic              last_err;
  logic              keep_err;
  logic              upper_err;
  logic [3:0]        err_code;
  logic              any_err;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; start has priority over stop
  always_comb begin
    next_state = state;
    if (start)     next_state = RUN;
    else if (stop) next_state = IDLE;
  end

  // FSM outputs: running flag and throttled ready
  always_comb begin
    running        = 1'b0;
    axis_in.tready = 1'b0;
    if (state == RUN) begin
      running        = 1'b1;
      axis_in.tready = (phase >= throttle);
    end
  end

  // Free-running backpressure phase, wraps every 16 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= 4'd0;
    else       phase <= phase + 4'd1;
  end

  // Upper data bits must be zero; nothing to check at the minimum width
  generate
    if (DW > 64) begin : g_upper
      assign upper_err = |axis_in.tdata[DW-1:64];
    end else begin : g_no_upper
      assign upper_err = 1'b0;
    end
  endgenerate

  assign accept   = axis_in.tvalid && axis_in.tready;
  assign data_err = (axis_in.tdata[63:0] != expected);
  assign last_err = (axis_in.tlast != (expected[3:0] == 4'hF));
  assign keep_err = (axis_in.tkeep != {KW{1'b1}});
  assign err_code = {upper_err, keep_err, last_err, data_err};
  assign any_err  = |err_code;

  // Statistics, expected-value tracking and first-error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected           <= '0;
      beat_count         <= '0;
      packet_count       <= '0;
      error_count        <= '0;
      error_flag         <= 1'b0;
      first_err_code     <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
    end else if (start) begin
      // A beat handshaken during a restart is dropped uncounted
      expected           <= '0;
      beat_count         <= '0;
      packet_count       <= '0;
      error_count        <= '0;
      error_flag         <= 1'b0;
      first_err_code     <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
    end else if (accept) begin
      beat_count   <= beat_count + 32'd1;
      packet_count <= packet_count + 32'(axis_in.tlast);
      // Resync on every beat so a single bad word yields a bounded error burst
      expected     <= axis_in.tdata[63:0] + 64'd1;
      if (any_err) begin
        if (error_count != ERR_MAX) error_count <= error_count + 16'd1;
        if (!error_flag) begin
          error_flag         <= 1'b1;
          first_err_code     <= err_code;
          first_err_expected <= expected;
          first_err_actual   <= axis_in.tdata[63:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_checker.sv
// Directed self-checking bench for data_checker.
module tb_data_checker;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  throttle;
  logic        running;
  logic [31:0] beat_count;
  logic [31:0] packet_count;
  logic [15:0] error_count;
  logic        error_flag;
  logic [3:0]  first_err_code;
  logic [63:0] first_err_expected;
  logic [63:0] first_err_actual;

  int n_checks = 0;
  int n_errors = 0;

  data_checker_if #(.DW(DW)) axis ();

  data_checker #(.DW(DW)) dut (
    .clk                (clk),
    .reset              (rst),
    .start              (start),
    .stop               (stop),
    .throttle           (throttle),
    .axis_in            (axis.slave),
    .running            (running),
    .beat_count         (beat_count),
    .packet_count       (packet_count),
    .error_count        (error_count),
    .error_flag         (error_flag),
    .first_err_code     (first_err_code),
    .first_err_expected (first_err_expected),
    .first_err_actual   (first_err_actual)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence wedges
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until handshaken; returns cycles spent
  task automatic send(input logic [63:0] v, input logic last, input logic [KW-1:0] keep,
                      input logic up, output int waits);
    logic acc;
    int   n;
    axis.tdata        = '0;
    axis.tdata[63:0]  = v;
    axis.tdata[100]   = up;
    axis.tkeep        = keep;
    axis.tlast        = last;
    axis.tvalid       = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      acc = axis.tready;
      tick();
      n++;
    end
    axis.tvalid = 1'b0;
    waits = n;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout observed=no_accept expected=accept v=0x%0h", v);
    end
  endtask

  task automatic send_ok(input logic [63:0] v, output int waits);
    send(v, (v[3:0] == 4'hF), {KW{1'b1}}, 1'b0, waits);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_tready"}, 64'(axis.tready), 64'd0);
    check({tag, "_beats"}, 64'(beat_count), 64'd0);
    check({tag, "_packets"}, 64'(packet_count), 64'd0);
    check({tag, "_errors"}, 64'(error_count), 64'd0);
    check({tag, "_flag"}, 64'(error_flag), 64'd0);
    check({tag, "_code"}, 64'(first_err_code), 64'd0);
    check({tag, "_fexp"}, first_err_expected, 64'd0);
    check({tag, "_fact"}, first_err_actual, 64'd0);
  endtask

  initial begin
    int w;
    int total;
    int ready_hi;

    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    throttle    = 4'd0;
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;
    axis.tvalid = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Nominal: 64 beats at full rate
    pulse_start();
    check("nom_running", 64'(running), 64'd1);
    total = 0;
    for (int i = 0; i < 64; i++) begin
      send_ok(64'(i), w);
      total += w;
    end
    check("nom_cycles", 64'(total), 64'd64);
    check("nom_beats", 64'(beat_count), 64'd64);
    check("nom_packets", 64'(packet_count), 64'd4);
    check("nom_errors", 64'(error_count), 64'd0);
    check("nom_flag", 64'(error_flag), 64'd0);

    // Backpressure: ready 4 of every 16 cycles
    throttle = 4'd12;
    pulse_start();
    ready_hi = 0;
    for (int i = 0; i < 32; i++) begin
      if (axis.tready) ready_hi++;
      tick();
    end
    check("bp_ready_cycles", 64'(ready_hi), 64'd8);
    for (int i = 0; i < 32; i++) send_ok(64'(i), w);
    check("bp_beats", 64'(beat_count), 64'd32);
    check("bp_packets", 64'(packet_count), 64'd2);
    check("bp_errors", 64'(error_count), 64'd0);

    // Data corruption at beat 10
    throttle = 4'd0;
    pulse_start();
    for (int i = 0; i < 10; i++) send_ok(64'(i), w);
    send(64'h1B, 1'b0, {KW{1'b1}}, 1'b0, w);
    check("cor_errors1", 64'(error_count), 64'd1);
    check("cor_code", 64'(first_err_code), 64'b0001);
    check("cor_fexp", first_err_expected, 64'h0A);
    check("cor_fact", first_err_actual, 64'h1B);
    for (int i = 11; i < 32; i++) send_ok(64'(i), w);
    check("cor_errors2", 64'(error_count), 64'd2);
    check("cor_beats", 64'(beat_count), 64'd32);
    check("cor_code_held", 64'(first_err_code), 64'b0001);
    check("cor_fexp_held", first_err_expected, 64'h0A);
    check("cor_fact_held", first_err_actual, 64'h1B);

    // Framing: spurious TLAST
    pulse_start();
    for (int i = 0; i < 5; i++) send_ok(64'(i), w);
    send(64'h5, 1'b1, {KW{1'b1}}, 1'b0, w);
    check("last_errors", 64'(error_count), 64'd1);
    check("last_code", 64'(first_err_code), 64'b0010);
    check("last_fexp", first_err_expected, 64'h5);

    // Framing: TKEEP cleared
    pulse_start();
    send_ok(64'd0, w);
    send_ok(64'd1, w);
    send(64'h2, 1'b0, {KW{1'b0}}, 1'b0, w);
    check("keep_errors", 64'(error_count), 64'd1);
    check("keep_code", 64'(first_err_code), 64'b0100);

    // Framing: non-zero upper data bit
    pulse_start();
    send(64'h0, 1'b0, {KW{1'b1}}, 1'b1, w);
    send_ok(64'd1, w);
    check("upper_errors", 64'(error_count), 64'd1);
    check("upper_code", 64'(first_err_code), 64'b1000);
    check("upper_beats", 64'(beat_count), 64'd2);

    // Stop with a beat in the same cycle: beat still counted, then frozen
    pulse_start();
    for (int i = 0; i < 19; i++) send_ok(64'(i), w);
    axis.tdata       = '0;
    axis.tdata[63:0] = 64'd19;
    axis.tkeep       = {KW{1'b1}};
    axis.tlast       = 1'b0;
    axis.tvalid      = 1'b1;
    stop             = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_running", 64'(running), 64'd0);
    check("stop_tready", 64'(axis.tready), 64'd0);
    check("stop_beats", 64'(beat_count), 64'd20);
    axis.tdata[63:0] = 64'd20;
    repeat (5) tick();
    axis.tvalid = 1'b0;
    check("stop_frozen", 64'(beat_count), 64'd20);
    check("stop_err", 64'(error_count), 64'd0);

    // Restart from IDLE, then restart from RUN with a beat in the start cycle
    pulse_start();
    check("rs_beats", 64'(beat_count), 64'd0);
    for (int i = 0; i < 3; i++) send_ok(64'(i), w);
    axis.tdata[63:0] = 64'd3;
    axis.tvalid      = 1'b1;
    pulse_start();
    axis.tvalid = 1'b0;
    check("rs_run_beats", 64'(beat_count), 64'd0);
    send_ok(64'd0, w);
    check("rs_exp_zero", 64'(error_count), 64'd0);
    check("rs_beats1", 64'(beat_count), 64'd1);

    // Reset asserted mid-packet with an error latched
    send(64'd5, 1'b0, {KW{1'b1}}, 1'b0, w);
    check("pre_rst_flag", 64'(error_flag), 64'd1);
    axis.tdata[63:0] = 64'd6;
    axis.tvalid      = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    axis.tvalid = 1'b0;
    tick();

    // 64-bit counter wrap after one resync error
    pulse_start();
    send(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, {KW{1'b1}}, 1'b0, w);
    send_ok(64'hFFFF_FFFF_FFFF_FFFF, w);
    send_ok(64'd0, w);
    send_ok(64'd1, w);
    check("wrap_errors", 64'(error_count), 64'd1);
    check("wrap_code", 64'(first_err_code), 64'b0001);
    check("wrap_fact", first_err_actual, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_beats", 64'(beat_count), 64'd4);
    check("wrap_packets", 64'(packet_count), 64'd1);

    // Error counter saturation
    pulse_start();
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;
    axis.tvalid = 1'b1;
    repeat (70000) tick();
    axis.tvalid = 1'b0;
    check("sat_errors", 64'(error_count), 64'hFFFF);
    check("sat_beats", 64'(beat_count), 64'd70000);
    check("sat_code", 64'(first_err_code), 64'b0100);
    tick();
    check("sat_hold", 64'(error_count), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
